// File: rtl/dmem_chk_pkg.sv
// Shared types and constants for the data-memory checker: FSM states,
// failure-cause encoding and the MMIO register map.
package dmem_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_WRONG    = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_MISALIGN = 2'd3
  } err_t;

  localparam logic [23:0] MMIO_PAGE  = 24'hFF_FFFF;
  localparam logic [31:0] ADR_STATUS = 32'hFFFF_FF00;
  localparam logic [31:0] ADR_CYCLES = 32'hFFFF_FF04;
  localparam logic [31:0] ADR_WCOUNT = 32'hFFFF_FF08;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: combinational read, write on the rising clock edge.
module dmem_ram #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // NOTE: storage has no reset on purpose; contents survive a checker reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_checker.sv
// Data memory for a CPU test harness that watches stores and decides
// pass/fail on the first data store of a run; status is readable over MMIO.
module dmem_checker
  import dmem_chk_pkg::*;
#(
  parameter int          DEPTH       = 64,
  parameter logic [31:0] EXPECT_ADR  = 32'd20,
  parameter logic [31:0] EXPECT_DATA = 32'd2,
  parameter int          TIMEOUT     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err
);

  localparam int AW = $clog2(DEPTH);

  state_t      r_state, w_state_nxt;
  err_t        r_err, w_err_nxt;
  logic [31:0] r_cycles;
  logic [15:0] r_wcount;

  logic        w_mmio, w_aligned, w_store, w_ram_we, w_rearm, w_match;
  logic [31:0] w_ram_rdata;

  assign w_mmio    = (DataAdr[31:8] == MMIO_PAGE);
  assign w_aligned = (DataAdr[1:0] == 2'b00);
  assign w_store   = MemWrite && !w_mmio;
  assign w_ram_we  = w_store && w_aligned;
  assign w_rearm   = MemWrite && (DataAdr == ADR_STATUS) && WriteData[0];
  assign w_match   = (DataAdr == EXPECT_ADR) && (WriteData == EXPECT_DATA);

  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (DataAdr[AW+1:2]),
    .i_wdata (WriteData),
    .o_rdata (w_ram_rdata)
  );

  // NOTE: defaults first so every path assigns both outputs and no latch forms.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    if (w_rearm) begin
      w_state_nxt = ST_RUN;
      w_err_nxt   = ERR_NONE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (w_store) begin
            if (!w_aligned) begin
              w_state_nxt = ST_FAIL;
              w_err_nxt   = ERR_MISALIGN;
            end else if (w_match) begin
              w_state_nxt = ST_PASS;
              w_err_nxt   = ERR_NONE;
            end else begin
              w_state_nxt = ST_FAIL;
              w_err_nxt   = ERR_WRONG;
            end
          end else if (r_cycles == 32'(TIMEOUT - 1)) begin
            w_state_nxt = ST_FAIL;
            w_err_nxt   = ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_err    <= ERR_NONE;
      r_cycles <= '0;
      r_wcount <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (w_rearm)                r_cycles <= '0;
      else if (r_state == ST_RUN) r_cycles <= r_cycles + 32'd1;
      if (w_rearm)                                  r_wcount <= '0;
      else if (w_ram_we && (r_wcount != 16'hFFFF)) r_wcount <= r_wcount + 16'd1;
    end
  end

  assign done = (r_state == ST_PASS) || (r_state == ST_FAIL);
  assign pass = (r_state == ST_PASS);
  assign err  = r_err;

  always_comb begin
    ReadData = w_ram_rdata;
    if (w_mmio) begin
      case (DataAdr)
        ADR_STATUS: ReadData = {28'b0, r_err, pass, done};
        ADR_CYCLES: ReadData = r_cycles;
        ADR_WCOUNT: ReadData = {16'b0, r_wcount};
        default:    ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_checker.sv
// Directed bench for dmem_checker: a default instance and a TIMEOUT=8
// instance share the same CPU-side stimulus.
module tb_dmem_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData, rdata8;
  logic        done, pass, done8, pass8;
  logic [1:0]  err, err8;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  dmem_checker u_dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .done(done), .pass(pass), .err(err)
  );

  dmem_checker #(.TIMEOUT(8)) u_dut8 (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(rdata8), .done(done8), .pass(pass8), .err(err8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = adr;
    WriteData = data;
    cycle();
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    MemWrite = 1'b0;
    DataAdr  = adr;
    #1;
    check(tag, ReadData, exp);
  endtask

  task automatic chk_rd8(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    MemWrite = 1'b0;
    DataAdr  = adr;
    #1;
    check(tag, rdata8, exp);
  endtask

  // Reset for n edges, then one edge to leave IDLE: lands in RUN cycle 1.
  task automatic start_run(input int n);
    reset = 1'b1;
    cycles(n);
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    // Reset state and a correct store in RUN cycle 5
    reset = 1'b1;
    cycles(2);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_pass", {31'b0, pass}, 32'd0);
    check("rst_err",  {30'b0, err},  32'd0);
    chk_rd("rst_status", 32'hFFFF_FF00, 32'd0);
    chk_rd("rst_cycles", 32'hFFFF_FF04, 32'd0);
    reset = 1'b0;
    cycle();
    check("run_done", {31'b0, done}, 32'd0);
    cycles(4);
    chk_rd("cyc_before", 32'hFFFF_FF04, 32'd4);
    store(32'd20, 32'd2);
    check("p1_done", {31'b0, done}, 32'd1);
    check("p1_pass", {31'b0, pass}, 32'd1);
    check("p1_err",  {30'b0, err},  32'd0);
    chk_rd("p1_cycles", 32'hFFFF_FF04, 32'd5);
    chk_rd("p1_status", 32'hFFFF_FF00, 32'd3);
    chk_rd("p1_ram",    32'd20,        32'd2);
    chk_rd("p1_wcount", 32'hFFFF_FF08, 32'd1);
    cycles(3);
    chk_rd("p1_hold", 32'hFFFF_FF04, 32'd5);

    // Wrong data, then a late correct store cannot pass
    start_run(1);
    store(32'd20, 32'd3);
    check("w_done", {31'b0, done}, 32'd1);
    check("w_pass", {31'b0, pass}, 32'd0);
    check("w_err",  {30'b0, err},  32'd1);
    chk_rd("w_status", 32'hFFFF_FF00, 32'd5);
    store(32'd20, 32'd2);
    check("w_late_pass", {31'b0, pass}, 32'd0);
    check("w_late_err",  {30'b0, err},  32'd1);
    chk_rd("w_wcount", 32'hFFFF_FF08, 32'd2);
    chk_rd("w_ram",    32'd20,        32'd2);

    // Misaligned store
    start_run(1);
    chk_rd("m_ram_kept", 32'd20, 32'd2);
    store(32'd22, 32'hDEAD_BEEF);
    check("m_done", {31'b0, done}, 32'd1);
    check("m_err",  {30'b0, err},  32'd3);
    chk_rd("m_ram",    32'd20,        32'd2);
    chk_rd("m_alias",  32'd276,       32'd2);
    chk_rd("m_wcount", 32'hFFFF_FF08, 32'd0);

    // Re-arm from FAIL, then pass; other MMIO stores are inert
    store(32'hFFFF_FF00, 32'd1);
    check("ra_done", {31'b0, done}, 32'd0);
    check("ra_err",  {30'b0, err},  32'd0);
    chk_rd("ra_cycles", 32'hFFFF_FF04, 32'd0);
    chk_rd("ra_wcount", 32'hFFFF_FF08, 32'd0);
    store(32'd20, 32'd2);
    check("ra_pass", {31'b0, pass}, 32'd1);
    chk_rd("ra_cyc2", 32'hFFFF_FF04, 32'd1);
    store(32'hFFFF_FF04, 32'd123);
    store(32'hFFFF_FF00, 32'd0);
    check("mm_pass", {31'b0, pass}, 32'd1);
    chk_rd("mm_wcount", 32'hFFFF_FF08, 32'd1);
    chk_rd("mm_cycles", 32'hFFFF_FF04, 32'd1);

    // Timeout on the TIMEOUT=8 instance
    start_run(1);
    cycles(7);
    check("t_not_yet", {31'b0, done8}, 32'd0);
    chk_rd8("t_cyc7", 32'hFFFF_FF04, 32'd7);
    cycle();
    check("t_done", {31'b0, done8}, 32'd1);
    check("t_err",  {30'b0, err8},  32'd2);
    chk_rd8("t_cyc8", 32'hFFFF_FF04, 32'd8);
    start_run(1);
    cycles(7);
    store(32'd20, 32'd2);
    check("t_last_pass", {31'b0, pass8}, 32'd1);
    check("t_last_err",  {30'b0, err8},  32'd0);

    // Reset mid-run; a word stored during reset survives
    reset = 1'b1;
    store(32'd40, 32'hCAFE_F00D);
    reset = 1'b0;
    cycle();
    chk_rd("r_wcount0", 32'hFFFF_FF08, 32'd0);
    cycles(2);
    chk_rd("r_cyc3", 32'hFFFF_FF04, 32'd2);
    reset = 1'b1;
    cycle();
    check("r_done", {31'b0, done}, 32'd0);
    chk_rd("r_cycles", 32'hFFFF_FF04, 32'd0);
    reset = 1'b0;
    chk_rd("r_ram", 32'd40, 32'hCAFE_F00D);
    cycles(2);
    chk_rd("r_run", 32'hFFFF_FF04, 32'd1);
    chk_rd("r_status", 32'hFFFF_FF00, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
